// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: byte width, header field layout and
// the tagged storage word used by the per-port output FIFOs.
package router_pkg;

  localparam int ROUTER_DATA_W = 8;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;
  localparam int LEN_LSB  = 2;
  localparam int LEN_W    = 6;

  typedef struct packed {
    logic                     tag;
    logic [ROUTER_DATA_W-1:0] data;
  } fifo_word_t;

  // Bytes still to follow a header: payload length plus the parity byte.
  function automatic logic [LEN_W:0] hdr_remaining(input logic [ROUTER_DATA_W-1:0] hdr);
    return {1'b0, hdr[LEN_LSB +: LEN_W]} + (LEN_W+1)'(1);
  endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// Storage for router_fifo: DEPTH words of WIDTH+1 bits, synchronous write and
// asynchronous (combinational) read.
module router_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [WIDTH:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [WIDTH:0] o_rdata
);

  logic [WIDTH:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router, with header tagging and packet
// length tracking. Define ROUTER_FIFO_TRISTATE_EN to float data_out between packets.
module router_fifo
  import router_pkg::*;
#(
  parameter int WIDTH = ROUTER_DATA_W,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [LEN_W:0]   r_pkt_cnt;
  logic [LEN_W:0]   w_pkt_cnt_nxt;
  logic [WIDTH-1:0] r_data_out;
  logic             w_wr_fire;
  logic             w_rd_fire;
  fifo_word_t       w_wr_word;
  fifo_word_t       w_rd_word;

  // The extra pointer MSB separates a full FIFO from an empty one.
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  assign w_wr_fire = write_enb && !full && !soft_reset;
  assign w_rd_fire = read_enb && !empty && !soft_reset;

  assign w_wr_word.tag  = lfd_state;
  assign w_wr_word.data = data_in;

  router_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_wr_fire),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wr_word),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_word)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (soft_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // A popped header reloads the count; every other popped byte consumes one.
  always_comb begin
    w_pkt_cnt_nxt = r_pkt_cnt;
    if (w_rd_fire) begin
      if (w_rd_word.tag) begin
        w_pkt_cnt_nxt = hdr_remaining(w_rd_word.data);
      end else if (r_pkt_cnt != '0) begin
        w_pkt_cnt_nxt = r_pkt_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pkt_cnt <= '0;
    end else if (soft_reset) begin
      r_pkt_cnt <= '0;
    end else begin
      r_pkt_cnt <= w_pkt_cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_data_out <= '0;
    end else if (soft_reset) begin
      r_data_out <= '0;
    end else if (w_rd_fire) begin
      r_data_out <= w_rd_word.data;
    end else if (r_pkt_cnt == '0) begin
      r_data_out <= '0;
    end
  end

`ifdef ROUTER_FIFO_TRISTATE_EN
  logic r_out_en;

  // The output floats whenever no packet byte is being presented.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_out_en <= 1'b0;
    end else if (soft_reset) begin
      r_out_en <= 1'b0;
    end else if (w_rd_fire) begin
      r_out_en <= 1'b1;
    end else if (r_pkt_cnt == '0) begin
      r_out_en <= 1'b0;
    end
  end

  assign data_out = r_out_en ? r_data_out : {WIDTH{1'bz}};
`else
  assign data_out = r_data_out;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: directed packet, full, wrap and flush sequences
// against a small queue model of the FIFO, its packet counter and its output register.
module tb_router_fifo;

  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int errors = 0;
  int checks = 0;

  logic [8:0] modelQ [$];
  logic [7:0] scbQ [$];
  logic [6:0] modelPkt;
  logic [7:0] expDout;
  logic [7:0] idleVal;
  logic       readFired;
  logic       rdSeen;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelClear();
    modelQ.delete();
    modelPkt = '0;
    expDout  = idleVal;
  endtask

  // One clock of stimulus, driven just after a falling edge; the model advances
  // at the rising edge and flags plus idle output are checked at the next fall.
  task automatic applyStimulus(input logic we, input logic re, input logic lfd,
                               input logic [7:0] din, input logic srst);
    logic [8:0] w;
    logic       mEmpty;
    logic       mFull;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = srst;
    @(posedge clock);
    readFired = 1'b0;
    if (srst) begin
      modelClear();
    end else begin
      mEmpty = (modelQ.size() == 0);
      mFull  = (modelQ.size() == 16);
      if (re && !mEmpty) begin
        readFired = 1'b1;
        w = modelQ.pop_front();
        scbQ.push_back(w[7:0]);
        expDout = w[7:0];
        if (w[8]) modelPkt = {1'b0, w[7:2]} + 7'd1;
        else if (modelPkt != 0) modelPkt = modelPkt - 7'd1;
      end else if (modelPkt == 0) begin
        expDout = idleVal;
      end
      if (we && !mFull) modelQ.push_back({lfd, din});
    end
    @(negedge clock);
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    soft_reset = 1'b0;
    checkOutput("full", {7'd0, full}, {7'd0, modelQ.size() == 16});
    checkOutput("empty", {7'd0, empty}, {7'd0, modelQ.size() == 0});
    if (!readFired) checkOutput("idleData", data_out, expDout);
  endtask

  // Monitor: a read accepted at a rising edge shows its byte by the next fall.
  always @(posedge clock) rdSeen <= read_enb && !empty && !soft_reset && resetn;

  always @(negedge clock) begin
    logic [7:0] e;
    if (rdSeen) begin
      if (scbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL readData: got %h with no read expected at %0t", data_out, $time);
      end else begin
        e = scbQ.pop_front();
        checkOutput("readData", data_out, e);
      end
    end
  end

  initial begin
`ifdef ROUTER_FIFO_TRISTATE_EN
    idleVal = 8'hzz;
`else
    idleVal = 8'h00;
`endif
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    modelClear();
    repeat (2) @(negedge clock);
    checkOutput("rstEmpty", {7'd0, empty}, 8'd1);
    checkOutput("rstFull", {7'd0, full}, 8'd0);
    checkOutput("rstData", data_out, idleVal);
    resetn = 1'b1;
    @(negedge clock);

    $display("[TB] async reset mid-write with 3 words held");
    applyStimulus(1, 0, 1, 8'h0E, 0);
    applyStimulus(1, 0, 0, 8'h11, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 8'h22, 0);
    applyStimulus(1, 0, 0, 8'h33, 0);
    write_enb = 1'b1;
    data_in   = 8'h44;
    #2 resetn = 1'b0;
    #1;
    checkOutput("midRstEmpty", {7'd0, empty}, 8'd1);
    checkOutput("midRstFull", {7'd0, full}, 8'd0);
    checkOutput("midRstData", data_out, idleVal);
    modelClear();
    @(negedge clock);
    write_enb = 1'b0;
    resetn    = 1'b1;
    @(negedge clock);

    $display("[TB] packet drain");
    applyStimulus(1, 0, 1, 8'h0E, 0);
    applyStimulus(1, 0, 0, 8'h11, 0);
    applyStimulus(1, 0, 0, 8'h22, 0);
    applyStimulus(1, 0, 0, 8'h33, 0);
    applyStimulus(1, 0, 0, 8'h1E, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);

    $display("[TB] fill to full, drop, simultaneous at full");
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 8'hA0 + 8'(i), 0);
    applyStimulus(1, 0, 0, 8'hFF, 0);
    applyStimulus(1, 1, 0, 8'hFF, 0);
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);

    $display("[TB] simultaneous at empty");
    applyStimulus(1, 1, 0, 8'h55, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);

    $display("[TB] wrap-around");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 8'(r * 16 + i + 1), 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 8'h00, 0);
    end

    $display("[TB] soft reset flush");
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 8'hC0 + 8'(i), 0);
    applyStimulus(1, 0, 0, 8'hEE, 1);
    applyStimulus(1, 0, 1, 8'h05, 0);
    applyStimulus(1, 0, 0, 8'h77, 0);
    applyStimulus(1, 0, 0, 8'h72, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);

    checkOutput("scbDrained", 8'(scbQ.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
